// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module   : hazard_ctrl_if
// Purpose  : Decode/execute/memory-stage hazard bus between the pipeline and
//            the hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if;
  // decode stage
  logic       dec_valid_in;
  logic [4:0] rs1_unreg_in;
  logic [4:0] rs2_unreg_in;
  logic       rs1_read_unreg_in;
  logic       rs2_read_unreg_in;
  // execute stage
  logic [4:0] ex_rd_in;
  logic       ex_rd_write_in;
  logic       ex_mem_read_in;
  logic       ex_mc_start_in;
  logic       ex_mc_done_in;
  logic       branch_taken_in;
  // memory stage
  logic [4:0] mem_rd_in;
  logic       mem_rd_write_in;
  // controller outputs
  logic        stall_out;
  logic        ex_stall_out;
  logic        bubble_out;
  logic        flush_out;
  logic [1:0]  fwd1_sel_out;
  logic [1:0]  fwd2_sel_out;
  logic        mc_timeout_out;
  logic [1:0]  state_out;
  logic [15:0] stall_cnt_out;

  // Pipeline side: drives stage status, receives control.
  modport master (
    output dec_valid_in, rs1_unreg_in, rs2_unreg_in, rs1_read_unreg_in,
           rs2_read_unreg_in, ex_rd_in, ex_rd_write_in, ex_mem_read_in,
           ex_mc_start_in, ex_mc_done_in, branch_taken_in, mem_rd_in,
           mem_rd_write_in,
    input  stall_out, ex_stall_out, bubble_out, flush_out, fwd1_sel_out,
           fwd2_sel_out, mc_timeout_out, state_out, stall_cnt_out
  );

  // Controller side.
  modport slave (
    input  dec_valid_in, rs1_unreg_in, rs2_unreg_in, rs1_read_unreg_in,
           rs2_read_unreg_in, ex_rd_in, ex_rd_write_in, ex_mem_read_in,
           ex_mc_start_in, ex_mc_done_in, branch_taken_in, mem_rd_in,
           mem_rd_write_in,
    output stall_out, ex_stall_out, bubble_out, flush_out, fwd1_sel_out,
           fwd2_sel_out, mc_timeout_out, state_out, stall_cnt_out
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller: RAW forwarding selects, load-use
//            bubbles, multi-cycle execute hold with watchdog, and branch
//            flush sequencing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MC_TIMEOUT   = 64
) (
  input wire           req,
  input wire           reset,
  hazard_ctrl_if.slave bus
);

  localparam logic [1:0]  c_ST_RUN      = 2'b00;
  localparam logic [1:0]  c_ST_MC       = 2'b01;
  localparam logic [1:0]  c_ST_FLUSH    = 2'b10;
  localparam logic [1:0]  c_FWD_RF      = 2'b00;
  localparam logic [1:0]  c_FWD_EX      = 2'b01;
  localparam logic [1:0]  c_FWD_MEM     = 2'b10;
  localparam logic [7:0]  c_MC_TIMEOUT  = 8'(MC_TIMEOUT);
  localparam logic [15:0] c_FLUSH_LOAD  = 16'(FLUSH_CYCLES - 1);
  // With a single flush cycle the entry cycle alone covers it.
  localparam bit          c_FLUSH_MULTI = (FLUSH_CYCLES > 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [7:0]  r_wdog;
  logic [15:0] r_flush_cnt;
  logic [15:0] r_stall_cnt;

  logic [1:0]  w_fwd1;
  logic [1:0]  w_fwd2;
  logic        w_load_use;
  logic        w_mc_enter;
  logic        w_timeout;
  logic        w_stall;
  logic        w_ex_stall;
  logic        w_bubble;
  logic        w_flush;

  // Execute result wins over memory result; loads in execute have no
  // result yet, and x0 is hard-wired so it is never forwarded.
  function automatic logic [1:0] f_fwd(
    input logic       rd_en,
    input logic [4:0] rs,
    input logic       ex_w,
    input logic       ex_ld,
    input logic [4:0] ex_rd,
    input logic       mem_w,
    input logic [4:0] mem_rd
  );
    if (rd_en && ex_w && (ex_rd != 5'd0) && (ex_rd == rs) && !ex_ld)
      return c_FWD_EX;
    else if (rd_en && mem_w && (mem_rd != 5'd0) && (mem_rd == rs))
      return c_FWD_MEM;
    else
      return c_FWD_RF;
  endfunction

  assign w_fwd1 = f_fwd(bus.rs1_read_unreg_in, bus.rs1_unreg_in, bus.ex_rd_write_in,
                        bus.ex_mem_read_in, bus.ex_rd_in, bus.mem_rd_write_in, bus.mem_rd_in);
  assign w_fwd2 = f_fwd(bus.rs2_read_unreg_in, bus.rs2_unreg_in, bus.ex_rd_write_in,
                        bus.ex_mem_read_in, bus.ex_rd_in, bus.mem_rd_write_in, bus.mem_rd_in);

  assign w_load_use = bus.dec_valid_in && bus.ex_mem_read_in && bus.ex_rd_write_in &&
                      (bus.ex_rd_in != 5'd0) &&
                      ((bus.rs1_read_unreg_in && (bus.rs1_unreg_in == bus.ex_rd_in)) ||
                       (bus.rs2_read_unreg_in && (bus.rs2_unreg_in == bus.ex_rd_in)));

  // Start together with done is a single-cycle op and never holds.
  assign w_mc_enter = bus.ex_mc_start_in && !bus.ex_mc_done_in;
  // A completing op on the watchdog's last cycle exits normally.
  assign w_timeout  = (r_state == c_ST_MC) && !bus.ex_mc_done_in && (r_wdog == c_MC_TIMEOUT);

  // State register.
  always_ff @(posedge req or negedge reset) begin
    if (!reset) r_state <= c_ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next-state selection; branch outranks a multi-cycle start in RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_RUN: begin
        if (bus.branch_taken_in)
          w_state_nxt = c_FLUSH_MULTI ? c_ST_FLUSH : c_ST_RUN;
        else if (w_mc_enter)
          w_state_nxt = c_ST_MC;
      end
      c_ST_MC: begin
        if (bus.ex_mc_done_in || w_timeout) w_state_nxt = c_ST_RUN;
      end
      c_ST_FLUSH: begin
        if (r_flush_cnt <= 16'd1) w_state_nxt = c_ST_RUN;
      end
      default: w_state_nxt = c_ST_RUN;
    endcase
  end

  // Control outputs per state; entry-cycle actions are taken from RUN.
  always_comb begin
    w_stall    = 1'b0;
    w_ex_stall = 1'b0;
    w_bubble   = 1'b0;
    w_flush    = 1'b0;
    case (r_state)
      c_ST_RUN: begin
        if (bus.branch_taken_in) begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
        end else if (w_mc_enter) begin
          w_stall    = 1'b1;
          w_ex_stall = 1'b1;
        end else if (w_load_use) begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
        end
      end
      c_ST_MC: begin
        w_stall    = !bus.ex_mc_done_in && !w_timeout;
        w_ex_stall = !bus.ex_mc_done_in && !w_timeout;
      end
      c_ST_FLUSH: begin
        w_flush  = 1'b1;
        w_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // Watchdog, flush down-counter and saturating stall counter.
  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      r_wdog      <= 8'd0;
      r_flush_cnt <= 16'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      if (r_state == c_ST_RUN && w_state_nxt == c_ST_MC)
        r_wdog <= 8'd1;
      else if (r_state == c_ST_MC && w_state_nxt == c_ST_MC)
        r_wdog <= r_wdog + 8'd1;
      else
        r_wdog <= 8'd0;

      if (r_state == c_ST_RUN && w_state_nxt == c_ST_FLUSH)
        r_flush_cnt <= c_FLUSH_LOAD;
      else if (r_state == c_ST_FLUSH && w_state_nxt == c_ST_FLUSH)
        r_flush_cnt <= r_flush_cnt - 16'd1;
      else
        r_flush_cnt <= 16'd0;

      if (w_stall && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // Every output is held at zero while reset is low, combinational ones too.
  assign bus.stall_out      = reset & w_stall;
  assign bus.ex_stall_out   = reset & w_ex_stall;
  assign bus.bubble_out     = reset & w_bubble;
  assign bus.flush_out      = reset & w_flush;
  assign bus.mc_timeout_out = reset & w_timeout;
  assign bus.fwd1_sel_out   = reset ? w_fwd1 : 2'b00;
  assign bus.fwd2_sel_out   = reset ? w_fwd2 : 2'b00;
  assign bus.state_out      = reset ? r_state : 2'b00;
  assign bus.stall_cnt_out  = reset ? r_stall_cnt : 16'd0;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl: vector table, directed
//            multi-cycle sequences and randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
  localparam int FLUSH_CYCLES = 2;
  localparam int MC_TIMEOUT   = 64;

  logic req   = 1'b0;
  logic reset = 1'b0;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .MC_TIMEOUT(MC_TIMEOUT)) dut (
    .req  (req),
    .reset(reset),
    .bus  (bus)
  );

  always #5 req = ~req;

  int checks = 0;
  int errors = 0;

  // reference model: mode 0 RUN, 1 MC_WAIT, 2 FLUSH
  int m_mode, m_age, m_owed, m_stalls;
  logic [1:0] e_f1, e_f2;
  logic e_stall, e_exs, e_bub, e_flush, e_mct;

  typedef struct {
    logic dv; logic [4:0] rs1; logic [4:0] rs2; logic r1; logic r2;
    logic [4:0] exrd; logic exw; logic exl; logic [4:0] memrd; logic memw;
    logic [1:0] f1; logic [1:0] f2; logic st; logic bub;
  } vec_t;
  vec_t vecs [11];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    bus.dec_valid_in = 0; bus.rs1_unreg_in = 0; bus.rs2_unreg_in = 0;
    bus.rs1_read_unreg_in = 0; bus.rs2_read_unreg_in = 0;
    bus.ex_rd_in = 0; bus.ex_rd_write_in = 0; bus.ex_mem_read_in = 0;
    bus.ex_mc_start_in = 0; bus.ex_mc_done_in = 0; bus.branch_taken_in = 0;
    bus.mem_rd_in = 0; bus.mem_rd_write_in = 0;
  endtask

  task automatic model_reset();
    m_mode = 0; m_age = 0; m_owed = 0; m_stalls = 0;
  endtask

  function automatic logic [1:0] ref_fwd(input logic rd, input logic [4:0] rs);
    if (rd && bus.ex_rd_write_in && bus.ex_rd_in != 0 && bus.ex_rd_in == rs && !bus.ex_mem_read_in)
      return 2'b01;
    if (rd && bus.mem_rd_write_in && bus.mem_rd_in != 0 && bus.mem_rd_in == rs)
      return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_eval();
    logic lu;
    e_f1 = ref_fwd(bus.rs1_read_unreg_in, bus.rs1_unreg_in);
    e_f2 = ref_fwd(bus.rs2_read_unreg_in, bus.rs2_unreg_in);
    lu = bus.dec_valid_in && bus.ex_mem_read_in && bus.ex_rd_write_in && bus.ex_rd_in != 0 &&
         ((bus.rs1_read_unreg_in && bus.rs1_unreg_in == bus.ex_rd_in) ||
          (bus.rs2_read_unreg_in && bus.rs2_unreg_in == bus.ex_rd_in));
    e_stall = 0; e_exs = 0; e_bub = 0; e_flush = 0; e_mct = 0;
    if (m_mode == 0) begin
      if (bus.branch_taken_in) begin e_flush = 1; e_bub = 1; end
      else if (bus.ex_mc_start_in && !bus.ex_mc_done_in) begin e_stall = 1; e_exs = 1; end
      else if (lu) begin e_stall = 1; e_bub = 1; end
    end else if (m_mode == 1) begin
      e_mct   = (m_age == MC_TIMEOUT) && !bus.ex_mc_done_in;
      e_stall = !bus.ex_mc_done_in && !e_mct;
      e_exs   = e_stall;
    end else begin
      e_flush = 1; e_bub = 1;
    end
  endtask

  task automatic model_update();
    if (e_stall && m_stalls < 65535) m_stalls++;
    if (m_mode == 0) begin
      if (bus.branch_taken_in) begin
        m_owed = FLUSH_CYCLES - 1;
        m_mode = (m_owed > 0) ? 2 : 0;
      end else if (bus.ex_mc_start_in && !bus.ex_mc_done_in) begin
        m_mode = 1; m_age = 1;
      end
    end else if (m_mode == 1) begin
      if (bus.ex_mc_done_in || e_mct) m_mode = 0;
      else m_age++;
    end else begin
      m_owed--;
      if (m_owed == 0) m_mode = 0;
    end
  endtask

  // Called at negedge+1 with inputs applied; returns at the next negedge+1.
  task automatic tick(input string tag);
    #1;
    model_eval();
    chk({tag, ".fwd1"},     16'(bus.fwd1_sel_out),   16'(e_f1));
    chk({tag, ".fwd2"},     16'(bus.fwd2_sel_out),   16'(e_f2));
    chk({tag, ".stall"},    16'(bus.stall_out),      16'(e_stall));
    chk({tag, ".ex_stall"}, 16'(bus.ex_stall_out),   16'(e_exs));
    chk({tag, ".bubble"},   16'(bus.bubble_out),     16'(e_bub));
    chk({tag, ".flush"},    16'(bus.flush_out),      16'(e_flush));
    chk({tag, ".mc_to"},    16'(bus.mc_timeout_out), 16'(e_mct));
    chk({tag, ".state"},    16'(bus.state_out),      16'(m_mode));
    chk({tag, ".stall_cnt"}, bus.stall_cnt_out,      16'(m_stalls));
    @(posedge req);
    model_update();
    @(negedge req);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".fwd1"},     16'(bus.fwd1_sel_out),   16'd0);
    chk({tag, ".fwd2"},     16'(bus.fwd2_sel_out),   16'd0);
    chk({tag, ".stall"},    16'(bus.stall_out),      16'd0);
    chk({tag, ".ex_stall"}, 16'(bus.ex_stall_out),   16'd0);
    chk({tag, ".bubble"},   16'(bus.bubble_out),     16'd0);
    chk({tag, ".flush"},    16'(bus.flush_out),      16'd0);
    chk({tag, ".mc_to"},    16'(bus.mc_timeout_out), 16'd0);
    chk({tag, ".state"},    16'(bus.state_out),      16'd0);
    chk({tag, ".stall_cnt"}, bus.stall_cnt_out,      16'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 0;
    #1;
    chk_zero(tag);
    model_reset();
    @(posedge req);
    @(negedge req);
    #1;
    reset = 1;
    clr_in();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    //        dv rs1   rs2   r1 r2 exrd  w  l  memrd w   f1     f2     st bub
    vecs[0]  = '{1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 5'd0, 0, 2'b01, 2'b00, 0, 0};
    vecs[1]  = '{1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 5'd0, 0, 2'b00, 2'b00, 0, 0};
    vecs[2]  = '{1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 5'd5, 1, 2'b01, 2'b00, 0, 0};
    vecs[3]  = '{1, 5'd0, 5'd5, 0, 1, 5'd0, 0, 0, 5'd5, 1, 2'b00, 2'b10, 0, 0};
    vecs[4]  = '{1, 5'd0, 5'd7, 0, 1, 5'd7, 1, 1, 5'd0, 0, 2'b00, 2'b00, 1, 1};
    vecs[5]  = '{1, 5'd0, 5'd7, 0, 1, 5'd0, 0, 0, 5'd7, 1, 2'b00, 2'b10, 0, 0};
    vecs[6]  = '{1, 5'd0, 5'd7, 0, 0, 5'd7, 1, 1, 5'd0, 0, 2'b00, 2'b00, 0, 0};
    vecs[7]  = '{0, 5'd7, 5'd0, 1, 0, 5'd7, 1, 1, 5'd0, 0, 2'b00, 2'b00, 0, 0};
    vecs[8]  = '{1, 5'd3, 5'd0, 1, 0, 5'd3, 0, 0, 5'd3, 1, 2'b10, 2'b00, 0, 0};
    vecs[9]  = '{1, 5'd4, 5'd9, 1, 1, 5'd4, 1, 0, 5'd9, 1, 2'b01, 2'b10, 0, 0};
    vecs[10] = '{1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 1, 5'd0, 0, 2'b00, 2'b00, 0, 0};

    // Reset asserted with forwarding-inducing inputs: everything must read 0.
    clr_in();
    bus.rs1_read_unreg_in = 1; bus.rs1_unreg_in = 5'd5;
    bus.ex_rd_in = 5'd5; bus.ex_rd_write_in = 1;
    #2;
    chk_zero("rst_hold");
    model_reset();
    @(posedge req); @(negedge req); #1;
    reset = 1;
    clr_in();
    #1;
    chk("post_rst.state", 16'(bus.state_out), 16'd0);
    chk("post_rst.stall_cnt", bus.stall_cnt_out, 16'd0);
    tick("post_rst");

    // Combinational forwarding / load-use vectors.
    for (int i = 0; i < 11; i++) begin
      bus.dec_valid_in = vecs[i].dv;
      bus.rs1_unreg_in = vecs[i].rs1; bus.rs2_unreg_in = vecs[i].rs2;
      bus.rs1_read_unreg_in = vecs[i].r1; bus.rs2_read_unreg_in = vecs[i].r2;
      bus.ex_rd_in = vecs[i].exrd; bus.ex_rd_write_in = vecs[i].exw;
      bus.ex_mem_read_in = vecs[i].exl;
      bus.mem_rd_in = vecs[i].memrd; bus.mem_rd_write_in = vecs[i].memw;
      #1;
      chk($sformatf("vec%0d.fwd1", i),   16'(bus.fwd1_sel_out), 16'(vecs[i].f1));
      chk($sformatf("vec%0d.fwd2", i),   16'(bus.fwd2_sel_out), 16'(vecs[i].f2));
      chk($sformatf("vec%0d.stall", i),  16'(bus.stall_out),    16'(vecs[i].st));
      chk($sformatf("vec%0d.bubble", i), 16'(bus.bubble_out),   16'(vecs[i].bub));
      tick($sformatf("vec%0d", i));
    end
    clr_in();

    // Multi-cycle op: start at cycle 0, done at cycle 4.
    do_reset("mc_rst");
    for (int c = 0; c <= 5; c++) begin
      bus.ex_mc_start_in = (c == 0);
      bus.ex_mc_done_in  = (c == 4);
      #1;
      chk($sformatf("mc%0d.stall", c), 16'(bus.stall_out), 16'(c <= 3));
      chk($sformatf("mc%0d.state", c), 16'(bus.state_out), (c >= 1 && c <= 4) ? 16'd1 : 16'd0);
      if (c == 5) chk("mc5.stall_cnt", bus.stall_cnt_out, 16'd4);
      tick($sformatf("mc%0d", c));
    end
    clr_in();

    // Watchdog: done never arrives.
    do_reset("to_rst");
    bus.ex_mc_start_in = 1;
    tick("to_start");
    bus.ex_mc_start_in = 0;
    for (int k = 1; k <= 66; k++) begin
      #1;
      chk($sformatf("to%0d.mc_to", k), 16'(bus.mc_timeout_out), 16'(k == MC_TIMEOUT));
      chk($sformatf("to%0d.state", k), 16'(bus.state_out), 16'(k <= MC_TIMEOUT));
      chk($sformatf("to%0d.stall", k), 16'(bus.stall_out), 16'(k < MC_TIMEOUT));
      tick($sformatf("to%0d", k));
    end

    // Branch with a simultaneous load-use hazard; start during FLUSH ignored.
    bus.dec_valid_in = 1; bus.rs2_read_unreg_in = 1; bus.rs2_unreg_in = 5'd7;
    bus.ex_rd_in = 5'd7; bus.ex_rd_write_in = 1; bus.ex_mem_read_in = 1;
    bus.branch_taken_in = 1;
    #1;
    chk("br0.flush", 16'(bus.flush_out), 16'd1);
    chk("br0.stall", 16'(bus.stall_out), 16'd0);
    chk("br0.bubble", 16'(bus.bubble_out), 16'd1);
    tick("br0");
    bus.branch_taken_in = 0; bus.ex_mem_read_in = 0; bus.ex_mc_start_in = 1;
    #1;
    chk("br1.flush", 16'(bus.flush_out), 16'd1);
    chk("br1.stall", 16'(bus.stall_out), 16'd0);
    chk("br1.state", 16'(bus.state_out), 16'd2);
    tick("br1");
    clr_in();
    #1;
    chk("br2.flush", 16'(bus.flush_out), 16'd0);
    chk("br2.state", 16'(bus.state_out), 16'd0);
    tick("br2");

    // Reset in the middle of MC_WAIT.
    bus.ex_mc_start_in = 1;
    tick("rmc_start");
    bus.ex_mc_start_in = 0;
    bus.rs1_read_unreg_in = 1; bus.rs1_unreg_in = 5'd5;
    bus.ex_rd_in = 5'd5; bus.ex_rd_write_in = 1;
    #1;
    chk("rmc.state", 16'(bus.state_out), 16'd1);
    chk("rmc.stall", 16'(bus.stall_out), 16'd1);
    chk("rmc.fwd1", 16'(bus.fwd1_sel_out), 16'd1);
    reset = 0;
    #1;
    chk_zero("rmc_rst");
    model_reset();
    @(posedge req); @(negedge req); #1;
    reset = 1;
    clr_in();
    #1;
    chk("rmc_rel.state", 16'(bus.state_out), 16'd0);
    chk("rmc_rel.stall_cnt", bus.stall_cnt_out, 16'd0);
    tick("rmc_rel");

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bus.dec_valid_in      = 1'($urandom_range(0, 3) != 0);
      bus.rs1_unreg_in      = 5'($urandom_range(0, 3));
      bus.rs2_unreg_in      = 5'($urandom_range(0, 3));
      bus.rs1_read_unreg_in = 1'($urandom);
      bus.rs2_read_unreg_in = 1'($urandom);
      bus.ex_rd_in          = 5'($urandom_range(0, 3));
      bus.ex_rd_write_in    = 1'($urandom);
      bus.mem_rd_in         = 5'($urandom_range(0, 3));
      bus.mem_rd_write_in   = 1'($urandom);
      bus.branch_taken_in   = 1'($urandom_range(0, 9) == 0);
      bus.ex_mc_start_in    = 1'($urandom_range(0, 7) == 0);
      bus.ex_mc_done_in     = 1'($urandom_range(0, 5) == 0);
      bus.ex_mem_read_in    = bus.ex_mc_start_in ? 1'b0 : 1'($urandom);
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that sequences the decode and execute stages. It detects read-after-write hazards between decode source registers and in-flight destinations, drives operand-forwarding selects, and inserts load-use bubbles. It holds the pipeline while a multi-cycle execute operation runs and flushes younger instructions after a taken branch. It sits beside `decode` and `execute` and owns every stall, bubble and flush signal between them.

## Interface
- `FLUSH_CYCLES`, 2, cycles `flush_out` stays high per taken branch (≥1)
- `MC_TIMEOUT`, 64, max cycles in MC_WAIT before forced exit (≥2, ≤255)
- `req` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low reset; one clock domain only
- `dec_valid_in` in 1: decode holds a valid instruction
- `rs1_unreg_in` / `rs2_unreg_in` in 5: decode source register indices
- `rs1_read_unreg_in` / `rs2_read_unreg_in` in 1: source actually read
- `ex_rd_in` in 5, `ex_rd_write_in` in 1, `ex_mem_read_in` in 1: destination, write enable and is-load flag of the instruction in execute
- `mem_rd_in` in 5, `mem_rd_write_in` in 1: destination and write enable of the instruction in memory stage
- `ex_mc_start_in` in 1: execute began a multi-cycle op this cycle
- `ex_mc_done_in` in 1: multi-cycle result valid this cycle
- `branch_taken_in` in 1: execute resolved a taken branch/jump
- `stall_out` out 1: hold fetch and decode registers
- `ex_stall_out` out 1: hold execute stage
- `bubble_out` out 1: load a NOP into execute
- `flush_out` out 1: invalidate fetch/decode contents
- `fwd1_sel_out` / `fwd2_sel_out` out 2: 00 register file, 01 execute result, 10 memory-stage result
- `mc_timeout_out` out 1: one-cycle pulse on watchdog expiry
- `state_out` out 2: 00 RUN, 01 MC_WAIT, 10 FLUSH
- `stall_cnt_out` out 16: count of cycles with `stall_out`=1, saturating

## Operation
- Forwarding, combinational, per source N: if read_N and `ex_rd_write_in` and `ex_rd_in`≠0 and `ex_rd_in`==rsN and not `ex_mem_read_in` → 01. Else if read_N and `mem_rd_write_in` and `mem_rd_in`≠0 and match → 10. Else 00. Execute has priority over memory. x0 is never forwarded.
- Load-use, RUN only: `dec_valid_in` and `ex_mem_read_in` and `ex_rd_write_in` and `ex_rd_in`≠0 and match on either read source → `stall_out`=1 and `bubble_out`=1 the same cycle. No state change. The hazard clears when the load advances.
- FSM, registered state:
  - RUN → FLUSH on `branch_taken_in`. `flush_out`=1 and `bubble_out`=1 the same cycle. Branch outranks load-use: the stall is suppressed because decode is discarded.
  - RUN → MC_WAIT on `ex_mc_start_in` and not `ex_mc_done_in`. `stall_out`=`ex_stall_out`=1 the same cycle. Start and done together means a single-cycle op: no stall, stay in RUN.
  - MC_WAIT: `stall_out`=`ex_stall_out`=NOT `ex_mc_done_in`. On done → RUN. Watchdog counts cycles in MC_WAIT. When it reaches `MC_TIMEOUT`: pulse `mc_timeout_out`, drop stalls that cycle, → RUN. `branch_taken_in` is ignored. Load-use detection is inactive.
  - FLUSH: `flush_out`=1, `bubble_out`=1. Flush counter loaded with `FLUSH_CYCLES`-1 on entry. Decrements each cycle; → RUN when it reads 1 (or immediately if `FLUSH_CYCLES`=1). Branch and start inputs are ignored.
- `stall_cnt_out` increments on each rising edge where `stall_out`=1 and saturates at 16'hFFFF.

## Timing
- Reset low: state RUN, all counters 0, `stall_cnt_out`=0. Every output is forced to 0 immediately and asynchronously, including combinational ones. Reset mid-MC_WAIT or mid-FLUSH aborts with no pulse.
- Forward selects, load-use stall and the entry-cycle stall/flush are combinational: zero latency, valid before the same `req` edge.
- State, watchdog, flush counter and `stall_cnt_out` update on the rising edge of `req`.
- Total `flush_out` high time per branch is exactly `FLUSH_CYCLES` cycles. Total MC stall time is N cycles when done arrives N cycles after start.

## Test plan
- ex: rd=5, write=1, load=0; decode rs1=5 read → `fwd1_sel_out`=01. Same with rd=0 → 00. Mem rd=5 and ex rd=5 → 01.
- Load in ex with rd=7, decode rs2=7 → `stall_out`=`bubble_out`=1 for one cycle. Next cycle mem rd=7 → `fwd2_sel_out`=10, no stall.
- Start at cycle 0, done at cycle 4 → `stall_out` high for cycles 0–3, `state_out`=01 for cycles 1–4, RUN at 5, `stall_cnt_out`=4.
- Start with done never asserted, `MC_TIMEOUT`=64 → `mc_timeout_out` pulses once at the 64th MC_WAIT cycle, then RUN.
- `branch_taken_in` together with a load-use hazard → `flush_out` high for 2 cycles, `stall_out`=0 throughout. Start during FLUSH is ignored.
- Reset low during MC_WAIT → all outputs 0 at once. After release, `state_out`=00 and `stall_cnt_out`=0.
